// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage
// Instruction-fetch stage of the 5-stage WISC-SP13 pipeline. Owns the PC, the
// instruction-memory request handshake (variable latency, zero-wait capable)
// and the IF/ID pipeline register, with a one-entry skid buffer that parks a
// returned word while decode is not accepting.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   PCSel_In_FromD           redirect request (honoured only with PCWrite)
//   BJAddr_In_FromD[15:0]    redirect target
//   PCWrite_In_FromD         0 = hold PC
//   IFWrite_In_FromD         0 = hold IF/ID
//   IFFlush_In_FromD         bubble the word entering IF/ID this cycle
//   Halt_In_FromD            decode holds HALT (taken with IFWrite)
//   IMemReq / IMemAddr       fetch request and address (stable while held)
//   IMemData/IMemDone/IMemErr memory response
//   Instr_Out_ToD / PCInc_Out_ToD / Valid_Out_ToD   IF/ID register
//   Halted                   fetch permanently stopped until reset
//   err                      sticky memory / misalignment error
// ============================================================================
module fetch_stage #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = 16'h0800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        PCSel_In_FromD,
   input  logic [15:0] BJAddr_In_FromD,
   input  logic        PCWrite_In_FromD,
   input  logic        IFWrite_In_FromD,
   input  logic        IFFlush_In_FromD,
   input  logic        Halt_In_FromD,
   output logic        IMemReq,
   output logic [15:0] IMemAddr,
   input  logic [15:0] IMemData,
   input  logic        IMemDone,
   input  logic        IMemErr,
   output logic [15:0] Instr_Out_ToD,
   output logic [15:0] PCInc_Out_ToD,
   output logic        Valid_Out_ToD,
   output logic        Halted,
   output logic        err
);

   localparam int unsigned W = 16;

   // FETCH: issuing (or waiting to issue) at PC. WAIT: request held.
   // HOLD: returned word parked in the skid. HALTED: terminal until reset.
   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_WAIT   = 2'd1,
      S_HOLD   = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   state_t         r_state;
   logic [W-1:0]   r_pc;
   logic [W-1:0]   r_addr;
   logic           r_req;
   logic           r_discard;      // outstanding response must be dropped
   logic           r_pend;         // PC+2 owed from a word accepted under PCWrite=0
   logic [W-1:0]   r_skid_instr;
   logic [W-1:0]   r_skid_pcinc;
   logic [W-1:0]   r_instr;
   logic [W-1:0]   r_pcinc;
   logic           r_valid;
   logic           r_halted;
   logic           r_err;

   // ---------------------------------------------------------------------
   // Next-state wires
   // ---------------------------------------------------------------------
   state_t         w_state_n;
   logic [W-1:0]   w_pc_n;
   logic [W-1:0]   w_addr_n;
   logic           w_req_n;
   logic           w_discard_n;
   logic           w_pend_n;
   logic [W-1:0]   w_skid_instr_n;
   logic [W-1:0]   w_skid_pcinc_n;
   logic [W-1:0]   w_instr_n;
   logic [W-1:0]   w_pcinc_n;
   logic           w_valid_n;
   logic           w_halted_n;
   logic           w_err_n;

   logic           w_done;
   logic           w_halt;
   logic           w_redir;
   logic           w_word;
   logic [W-1:0]   w_addr_inc;
   logic [W-1:0]   w_pc_inc;

   // Response qualifiers; a response only counts against a live request.
   assign w_done     = r_req & IMemDone;
   assign w_word     = w_done & ~r_discard;
   assign w_halt     = Halt_In_FromD & IFWrite_In_FromD;
   assign w_redir    = PCSel_In_FromD & PCWrite_In_FromD;
   assign w_addr_inc = r_addr + W'(2);
   assign w_pc_inc   = r_pc + W'(2);

   // Next-state and IF/ID update
   always_comb begin
      w_state_n      = r_state;
      w_pc_n         = r_pc;
      w_addr_n       = r_addr;
      w_req_n        = r_req;
      w_discard_n    = r_discard;
      w_pend_n       = r_pend;
      w_skid_instr_n = r_skid_instr;
      w_skid_pcinc_n = r_skid_pcinc;
      w_instr_n      = r_instr;
      w_pcinc_n      = r_pcinc;
      w_valid_n      = r_valid;
      w_halted_n     = r_halted;
      // Misalignment is flagged on every cycle an odd address is presented.
      w_err_n        = r_err | (w_done & IMemErr) | (r_req & r_addr[0]);

      if (r_state == S_HALTED) begin
         // Drain a request left outstanding at halt, then stay idle.
         w_instr_n = NOP_INSTR;
         w_valid_n = 1'b0;
         if (w_done) begin
            w_req_n     = 1'b0;
            w_discard_n = 1'b0;
         end
      end else if (w_halt) begin
         // Halt wins over any simultaneous redirect.
         w_state_n  = S_HALTED;
         w_halted_n = 1'b1;
         w_instr_n  = NOP_INSTR;
         w_valid_n  = 1'b0;
         w_pend_n   = 1'b0;
         if (r_req && !IMemDone) begin
            w_req_n     = 1'b1;
            w_discard_n = 1'b1;
         end else begin
            w_req_n     = 1'b0;
            w_discard_n = 1'b0;
         end
      end else begin
         // IF/ID: redirect/flush kill the entering word; otherwise skid first,
         // then a fresh response, else a bubble.
         if (w_redir || IFFlush_In_FromD) begin
            w_instr_n = NOP_INSTR;
            w_valid_n = 1'b0;
         end else if (IFWrite_In_FromD) begin
            if (r_state == S_HOLD) begin
               w_instr_n = r_skid_instr;
               w_pcinc_n = r_skid_pcinc;
               w_valid_n = 1'b1;
            end else if (w_word) begin
               w_instr_n = IMemData;
               w_pcinc_n = w_addr_inc;
               w_valid_n = 1'b1;
            end else begin
               w_instr_n = NOP_INSTR;
               w_valid_n = 1'b0;
            end
         end

         // PC and fetch sequencing
         if (w_redir) begin
            w_pc_n    = BJAddr_In_FromD;
            w_pend_n  = 1'b0;
            w_state_n = S_FETCH;
            if (r_req && !IMemDone) begin
               // Keep the old request on the bus and drop its response.
               w_discard_n = 1'b1;
               w_state_n   = S_WAIT;
            end else begin
               w_discard_n = 1'b0;
            end
         end else if (w_done) begin
            w_discard_n = 1'b0;
            w_state_n   = S_FETCH;
            if (!r_discard) begin
               if (PCWrite_In_FromD) begin
                  w_pc_n = w_addr_inc;
               end else begin
                  w_pend_n = 1'b1;
               end
               if (!IFWrite_In_FromD) begin
                  w_skid_instr_n = IMemData;
                  w_skid_pcinc_n = w_addr_inc;
                  w_state_n      = S_HOLD;
               end
            end
         end else if (r_req) begin
            w_state_n = S_WAIT;
         end else begin
            // Idle in FETCH or HOLD: settle an owed PC step once allowed.
            if (r_pend && PCWrite_In_FromD) begin
               w_pc_n   = w_pc_inc;
               w_pend_n = 1'b0;
            end
            if ((r_state == S_HOLD) && IFWrite_In_FromD) begin
               w_state_n = S_FETCH;
            end
         end

         // A new request is issued on entering FETCH unless a PC step is
         // still owed; the address only changes when a new request starts.
         w_req_n = (w_state_n == S_WAIT) || ((w_state_n == S_FETCH) && !w_pend_n);
         if (w_state_n == S_FETCH) begin
            w_addr_n = w_pc_n;
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_FETCH;
         r_pc         <= RESET_PC;
         r_addr       <= RESET_PC;
         r_req        <= 1'b0;
         r_discard    <= 1'b0;
         r_pend       <= 1'b0;
         r_skid_instr <= NOP_INSTR;
         r_skid_pcinc <= RESET_PC;
         r_instr      <= NOP_INSTR;
         r_pcinc      <= RESET_PC;
         r_valid      <= 1'b0;
         r_halted     <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_state      <= w_state_n;
         r_pc         <= w_pc_n;
         r_addr       <= w_addr_n;
         r_req        <= w_req_n;
         r_discard    <= w_discard_n;
         r_pend       <= w_pend_n;
         r_skid_instr <= w_skid_instr_n;
         r_skid_pcinc <= w_skid_pcinc_n;
         r_instr      <= w_instr_n;
         r_pcinc      <= w_pcinc_n;
         r_valid      <= w_valid_n;
         r_halted     <= w_halted_n;
         r_err        <= w_err_n;
      end
   end

   assign IMemReq       = r_req;
   assign IMemAddr      = r_addr;
   assign Instr_Out_ToD = r_instr;
   assign PCInc_Out_ToD = r_pcinc;
   assign Valid_Out_ToD = r_valid;
   assign Halted        = r_halted;
   assign err           = r_err;

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
module tb_fetch_stage;

   localparam logic [15:0] NOP = 16'h0800;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        sel, pcw, ifw, flush, halt;
   logic [15:0] bj;
   logic        IMemReq, IMemDone, IMemErr;
   logic [15:0] IMemAddr, IMemData;
   logic [15:0] Instr;
   logic [15:0] PCInc;
   logic        Valid, Halted, err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk(clk), .rst(rst),
      .PCSel_In_FromD(sel), .BJAddr_In_FromD(bj),
      .PCWrite_In_FromD(pcw), .IFWrite_In_FromD(ifw),
      .IFFlush_In_FromD(flush), .Halt_In_FromD(halt),
      .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemData(IMemData),
      .IMemDone(IMemDone), .IMemErr(IMemErr),
      .Instr_Out_ToD(Instr), .PCInc_Out_ToD(PCInc), .Valid_Out_ToD(Valid),
      .Halted(Halted), .err(err)
   );

   // ---------------- memory model ----------------
   function automatic logic [15:0] mdata(input logic [15:0] a);
      return 16'h4000 + a;
   endfunction

   logic [7:0]  m_cnt;
   int unsigned m_lat_fixed = 0;
   int unsigned m_lat_rand  = 0;
   logic        m_rand   = 1'b0;
   logic        m_err_en = 1'b0;
   int unsigned m_lat;

   assign m_lat    = m_rand ? m_lat_rand : m_lat_fixed;
   assign IMemDone = IMemReq && (32'(m_cnt) >= m_lat);
   assign IMemData = IMemDone ? mdata(IMemAddr) : 16'hDEAD;
   assign IMemErr  = IMemDone & m_err_en;

   always @(posedge clk or negedge rst) begin
      if (!rst)                       m_cnt <= 8'd0;
      else if (IMemReq && !IMemDone)  m_cnt <= m_cnt + 8'd1;
      else                            m_cnt <= 8'd0;
   end

   always @(posedge clk) if (IMemDone) m_lat_rand <= $urandom_range(0, 3);

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic a_ifw, input logic a_pcw, input logic a_sel,
                        input logic [15:0] a_bj, input logic a_fl, input logic a_ht);
      ifw = a_ifw; pcw = a_pcw; sel = a_sel; bj = a_bj; flush = a_fl; halt = a_ht;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        ifw, pcw, sel;
      logic [15:0] bj;
      logic        fl;
      logic        req;
      logic [15:0] addr;
      logic        v;
      logic [15:0] ins, pci;
   } vec_t;

   vec_t tv [0:17];

   function automatic vec_t mk(input logic a_ifw, input logic a_pcw, input logic a_sel,
                               input logic [15:0] a_bj, input logic a_fl, input logic a_req,
                               input logic [15:0] a_addr, input logic a_v,
                               input logic [15:0] a_ins, input logic [15:0] a_pci);
      vec_t t;
      t.ifw = a_ifw; t.pcw = a_pcw; t.sel = a_sel; t.bj = a_bj; t.fl = a_fl;
      t.req = a_req; t.addr = a_addr; t.v = a_v; t.ins = a_ins; t.pci = a_pci;
      return t;
   endfunction

   // ---------------- test sequence ----------------
   initial begin : main
      logic        found, seen6;
      logic [15:0] exp_pc, p_instr, p_pcinc, p_addr;
      logic        p_valid, p_req, p_done;
      int          delivered;

      drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

      // Zero-wait memory: stream, skid stall, redirect, flush, PC-only stall.
      tv[0]  = mk(1,1,0,16'h0000,0, 0,16'h0000,0,NOP,     16'h0000);
      tv[1]  = mk(1,1,0,16'h0000,0, 1,16'h0000,0,NOP,     16'h0000);
      tv[2]  = mk(1,1,0,16'h0000,0, 1,16'h0002,1,16'h4000,16'h0002);
      tv[3]  = mk(1,1,0,16'h0000,0, 1,16'h0004,1,16'h4002,16'h0004);
      tv[4]  = mk(0,0,0,16'h0000,0, 1,16'h0006,1,16'h4004,16'h0006);
      tv[5]  = mk(0,0,0,16'h0000,0, 0,16'h0006,1,16'h4004,16'h0006);
      tv[6]  = mk(1,1,0,16'h0000,0, 0,16'h0006,1,16'h4004,16'h0006);
      tv[7]  = mk(1,1,0,16'h0000,0, 1,16'h0008,1,16'h4006,16'h0008);
      tv[8]  = mk(1,1,1,16'h0100,0, 1,16'h000A,1,16'h4008,16'h000A);
      tv[9]  = mk(1,1,0,16'h0000,0, 1,16'h0100,0,NOP,     16'h000A);
      tv[10] = mk(1,1,0,16'h0000,0, 1,16'h0102,1,16'h4100,16'h0102);
      tv[11] = mk(1,1,0,16'h0000,1, 1,16'h0104,1,16'h4102,16'h0104);
      tv[12] = mk(1,1,0,16'h0000,0, 1,16'h0106,0,NOP,     16'h0104);
      tv[13] = mk(1,0,0,16'h0000,0, 1,16'h0108,1,16'h4106,16'h0108);
      tv[14] = mk(1,0,0,16'h0000,0, 0,16'h0108,1,16'h4108,16'h010A);
      tv[15] = mk(1,1,0,16'h0000,0, 0,16'h0108,0,NOP,     16'h010A);
      tv[16] = mk(1,1,0,16'h0000,0, 1,16'h010A,0,NOP,     16'h010A);
      tv[17] = mk(1,1,0,16'h0000,0, 1,16'h010C,1,16'h410A,16'h010C);

      m_rand = 1'b0; m_lat_fixed = 0;
      do_reset();
      for (int i = 0; i < 18; i++) begin
         drive(tv[i].ifw, tv[i].pcw, tv[i].sel, tv[i].bj, tv[i].fl, 1'b0);
         #1;
         check($sformatf("vec%0d", i),
               64'({IMemReq, IMemAddr, Valid, Instr, PCInc}),
               64'({tv[i].req, tv[i].addr, tv[i].v, tv[i].ins, tv[i].pci}));
         step();
      end
      drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

      // 3-cycle memory latency, then redirect during WAIT at PC=6.
      m_lat_fixed = 2;
      do_reset();
      check("lat_idle", 64'(IMemReq), 64'd0);
      step();
      for (int k = 1; k <= 3; k++) begin
         check($sformatf("lat_wait%0d", k), 64'({IMemReq, IMemAddr, Valid}), 64'({1'b1, 16'h0000, 1'b0}));
         step();
      end
      check("lat_first", 64'({IMemReq, IMemAddr, Valid, Instr, PCInc}),
            64'({1'b1, 16'h0002, 1'b1, 16'h4000, 16'h0002}));
      step();
      check("lat_bubble", 64'(Valid), 64'd0);
      step(); step();
      check("lat_second", 64'({IMemReq, IMemAddr, Valid, Instr, PCInc}),
            64'({1'b1, 16'h0004, 1'b1, 16'h4002, 16'h0004}));
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         if (IMemReq && IMemAddr == 16'h0006) found = 1'b1;
         else step();
      end
      check("reach_pc6", 64'(found), 64'd1);
      step();
      drive(1'b1, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0);
      step();
      drive(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      check("redir_hold_req", 64'({IMemReq, IMemAddr, Valid}), 64'({1'b1, 16'h0006, 1'b0}));
      seen6 = 1'b0; found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         if (Valid && Instr == 16'h4006) seen6 = 1'b1;
         if (IMemReq && IMemAddr != 16'h0006) found = 1'b1;
         else step();
      end
      check("redir_next_addr", 64'({found, IMemAddr}), 64'({1'b1, 16'h0100}));
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         if (Valid) found = 1'b1;
         else step();
      end
      check("redir_target_word", 64'({found, Instr, PCInc}), 64'({1'b1, 16'h4100, 16'h0102}));
      check("word6_dropped", 64'(seen6), 64'd0);

      // Halt with zero-wait memory; simultaneous redirect must be ignored.
      m_lat_fixed = 0;
      do_reset();
      step(); step(); step();
      drive(1'b1, 1'b1, 1'b1, 16'h0200, 1'b0, 1'b1);
      step();
      drive(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
      check("halt_enter", 64'({Halted, IMemReq, Valid, IMemAddr}), 64'({1'b1, 1'b0, 1'b0, 16'h0004}));
      for (int k = 0; k < 12; k++) begin
         step();
         check($sformatf("halted%0d", k), 64'({Halted, IMemReq, Valid, IMemAddr}),
               64'({1'b1, 1'b0, 1'b0, 16'h0004}));
      end
      #2 rst = 1'b0;
      #1 check("halt_reset", 64'({Halted, IMemReq, IMemAddr}), 64'({1'b0, 1'b0, 16'h0000}));
      drive(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      @(negedge clk); rst = 1'b1;
      step();
      check("halt_restart", 64'({IMemReq, IMemAddr}), 64'({1'b1, 16'h0000}));

      // Halt while a request is outstanding: held until Done, then idle.
      m_lat_fixed = 3;
      do_reset();
      step(); step();
      drive(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
      step();
      check("halt_pending", 64'({Halted, IMemReq, IMemAddr}), 64'({1'b1, 1'b1, 16'h0000}));
      found = 1'b0; seen6 = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         if (Valid) seen6 = 1'b1;
         if (!IMemReq) found = 1'b1;
         else step();
      end
      repeat (4) begin
         step();
         if (IMemReq || Valid) seen6 = 1'b1;
      end
      check("halt_drain", 64'({found, seen6}), 64'({1'b1, 1'b0}));

      // Sticky err from IMemErr, async clear, then misaligned redirect.
      m_lat_fixed = 0;
      do_reset();
      drive(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      check("err_reset", 64'(err), 64'd0);
      step(); step();
      m_err_en = 1'b1;
      step();
      m_err_en = 1'b0;
      check("err_set", 64'(err), 64'd1);
      repeat (5) step();
      check("err_sticky", 64'(err), 64'd1);
      #2 rst = 1'b0;
      #1 check("err_async_clear", 64'(err), 64'd0);
      @(negedge clk); rst = 1'b1;
      step(); step(); step();
      drive(1'b1, 1'b1, 1'b1, 16'h0011, 1'b0, 1'b0);
      step();
      drive(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      check("misalign_issue", 64'({IMemReq, IMemAddr, err}), 64'({1'b1, 16'h0011, 1'b0}));
      step();
      check("misalign_err", 64'({err, IMemAddr, Valid, Instr, PCInc}),
            64'({1'b1, 16'h0013, 1'b1, 16'h4011, 16'h0013}));

      // Randomized: decode handshakes vs. a program-order stream model.
      m_rand = 1'b1;
      do_reset();
      exp_pc = 16'h0000;
      delivered = 0;
      for (int c = 0; c < 800; c++) begin
         ifw = ($urandom_range(0, 99) < 75);
         pcw = ifw ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
         sel = ($urandom_range(0, 19) == 0);
         flush = 1'b0; halt = 1'b0; bj = 16'h0000;
         if (sel) begin
            ifw = 1'b1; pcw = 1'b1;
            flush = 1'($urandom_range(0, 1));
            bj = ($urandom_range(0, 7) == 0) ? 16'hFFFC : 16'($urandom_range(0, 2047) * 2);
         end
         #1;
         p_instr = Instr; p_pcinc = PCInc; p_valid = Valid;
         p_req = IMemReq; p_addr = IMemAddr; p_done = IMemDone;
         step();
         if (sel) begin
            check("rnd_redirect_bubble", 64'(Valid), 64'd0);
            exp_pc = bj;
         end else if (ifw) begin
            if (Valid) begin
               check("rnd_stream", 64'({Instr, PCInc}), 64'({mdata(exp_pc), 16'(exp_pc + 16'd2)}));
               exp_pc = exp_pc + 16'd2;
               delivered++;
            end
         end else begin
            check("rnd_ifid_hold", 64'({Instr, PCInc, Valid}), 64'({p_instr, p_pcinc, p_valid}));
         end
         if (p_req && !p_done)
            check("rnd_req_stable", 64'({IMemReq, IMemAddr}), 64'({1'b1, p_addr}));
      end
      check("rnd_progress", 64'(delivered >= 80), 64'd1);
      check("rnd_no_err", 64'(err), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage WISC-SP13 pipeline, directly upstream of decode.
- Owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register.
- Drives Instr/PCInc into decode.
- Consumes decode's redirect (PCSel/BJAddr), hazard (PCWrite/IFWrite), flush and halt signals.
- Tolerates variable-latency instruction memory; buffers a returned word while decode is stalled.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'h0800, bubble instruction inserted into IF/ID

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
PCSel_In_FromD  input  1  redirect request from decode
BJAddr_In_FromD  input  16  redirect target
PCWrite_In_FromD  input  1  0 = hold PC (load-use stall)
IFWrite_In_FromD  input  1  0 = hold IF/ID (decode not accepting)
IFFlush_In_FromD  input  1  bubble IF/ID this cycle
Halt_In_FromD  input  1  decode holds HALT
IMemReq  output  1  fetch request, held until IMemDone
IMemAddr  output  16  fetch address, stable while IMemReq=1
IMemData  input  16  instruction word, valid when IMemDone=1
IMemDone  input  1  fetch complete; may assert in the same cycle as IMemReq
IMemErr  input  1  memory error, sampled with IMemDone
Instr_Out_ToD  output  16  IF/ID instruction
PCInc_Out_ToD  output  16  IF/ID PC+2
Valid_Out_ToD  output  1  IF/ID holds a real instruction
Halted  output  1  fetch permanently stopped
err  output  1  sticky error

Behaviour:
Reset (asynchronous assert, synchronous release):
- PC=RESET_PC; Instr_Out_ToD=NOP_INSTR; PCInc_Out_ToD=RESET_PC; Valid_Out_ToD=0.
- IMemReq=0; Halted=0; err=0; discard=0; skid empty; state=FETCH.
- Reset mid-fetch abandons the request. The memory model must also reset.

States: FETCH, WAIT, HOLD, HALTED.
- FETCH: IMemReq=1, IMemAddr=PC.
  - IMemDone=1 → word accepted this cycle (zero-wait).
  - Otherwise → WAIT.
- WAIT: IMemReq=1, IMemAddr held. Stay until IMemDone.
- On accept with discard=0:
  - IFWrite=1 and no redirect/flush: IF/ID<={IMemData, PC+2}, Valid=1. If PCWrite, PC<=PC+2. Next state FETCH.
  - IFWrite=0: word and PC+2 go to the skid register; PC<=PC+2 only if PCWrite. Next state HOLD.
- On accept with discard=1: drop the word, clear discard, next state FETCH (PC already holds the target).
- HOLD: IMemReq=0. When IFWrite=1, IF/ID<=skid, then go to FETCH. A redirect in HOLD empties the skid.
- No word available and IFWrite=1 (FETCH without Done, or WAIT): IF/ID<={NOP_INSTR, PCInc unchanged}, Valid=0.
- IFWrite=0: IF/ID holds its value.

PC arithmetic:
- PC+2 is a 16-bit modulo add; 16'hFFFE wraps to 16'h0000.
- Issuing a request with PC[0]=1 sets err; the fetch still proceeds.

Redirect (PCSel=1 and PCWrite=1):
- PC<=BJAddr; IF/ID<=bubble; skid cleared.
- If a request is outstanding without Done this cycle, set discard.
- If Done arrives in the same cycle, drop that word.
- Redirect wins over the normal PC+2 update.
- PCSel with PCWrite=0 is ignored; decode re-evaluates next cycle.

IFFlush without PCSel: bubble IF/ID only; PC unaffected.

Halt (Halt_In_FromD=1 and IFWrite=1):
- State→HALTED; Halted=1; PC frozen; IF/ID<=bubble every cycle.
- An outstanding request is held until Done, then its word is discarded. IMemReq then stays 0.
- Exit HALTED only by reset.
- Simultaneous PCSel is ignored.

err:
- Sticky OR of (IMemDone & IMemErr) and misaligned issue.
- Cleared only by reset.

Test Plan:
- Zero-wait memory, IMemData=16'h4000+addr, reset release → IMemAddr sequence 0,2,4; Instr_Out_ToD=16'h4000,16'h4002 on consecutive cycles; PCInc_Out_ToD=2,4; Valid=1 from the second cycle.
- 3-cycle memory latency → IMemReq high 3 cycles with IMemAddr stable; two NOP bubbles (Valid=0), then the instruction; PC advances by 2 once per fetch.
- IFWrite=PCWrite=0 for 2 cycles with Done in the first → word held in skid, IMemReq=0, IF/ID unchanged; released the cycle after IFWrite=1; no word lost or duplicated.
- PCSel=1, BJAddr=16'h0100 during WAIT at PC=6 → Done word from 6 dropped; next IMemAddr=16'h0100; IF/ID bubble; 16'h0100's word appears with PCInc=16'h0102.
- Halt_In_FromD=1 with IFWrite=1 → Halted=1 next cycle; IMemReq stays 0; Valid stays 0 for 10+ cycles; rst low returns PC=RESET_PC.
- IMemErr=1 with Done, plus a redirect to 16'h0011 → err=1 and remains set; rst low clears err asynchronously.
